// File: rtl/circuit1_pkg.sv
// Shared constants for the circuit1 110 -> 111 -> 101 sequence detector.
package circuit1_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GOT110 = 2'b01;
  localparam logic [1:0] GOT111 = 2'b10;
  localparam logic [1:0] DETECT = 2'b11;

  localparam logic [2:0] PAT_A = 3'b110;
  localparam logic [2:0] PAT_B = 3'b111;
  localparam logic [2:0] PAT_C = 3'b101;

endpackage

// File: rtl/circuit1_set_reset_sr_dff.sv
// 1-bit D flip-flop with asynchronous active-low clear (dominant) and set.
module sr_dff (
  input  logic clk,
  input  logic clr,
  input  logic set,
  input  logic d,
  output logic q
);

  logic q_q;

  // Storage gives set precedence so that releasing clear while set is still
  // held exposes the set value without a clock edge; clear dominance is then
  // restored on the visible output.
  always_ff @(posedge clk or negedge clr or negedge set) begin
    if (!set) begin
      q_q <= 1'b1;
    end else if (!clr) begin
      q_q <= 1'b0;
    end else begin
      q_q <= d;
    end
  end

  assign q = clr & q_q;

endmodule

// File: rtl/circuit1_set_reset.sv
// Moore detector for {x1,x2,x3} = 110 -> 111 -> 101 with async clear/set state flops.
module circuit1_set_reset
  import circuit1_pkg::*;
(
  input  logic clk,
  input  logic cd,
  input  logic sd,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic z
);

  logic [2:0] x;
  logic [1:0] state_q;
  logic [1:0] state_d;

  assign x = {x1, x2, x3};

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (x == PAT_A) state_d = GOT110;
      end
      GOT110: begin
        if (x == PAT_B)      state_d = GOT111;
        else if (x == PAT_A) state_d = GOT110;
      end
      GOT111: begin
        if (x == PAT_C)      state_d = DETECT;
        else if (x == PAT_A) state_d = GOT110;
      end
      DETECT: begin
        if (x == PAT_A) state_d = GOT110;
      end
      default: state_d = IDLE;
    endcase
  end

  // One explicit flop per state bit so each can be targeted individually.
  sr_dff u_q1 (
    .clk (clk),
    .clr (cd),
    .set (sd),
    .d   (state_d[1]),
    .q   (state_q[1])
  );

  sr_dff u_q0 (
    .clk (clk),
    .clr (cd),
    .set (sd),
    .d   (state_d[0]),
    .q   (state_q[0])
  );

  always_comb begin
    z = (state_q == DETECT);
  end

endmodule

// File: tb/tb_circuit1_set_reset.sv
// Directed-vector bench for circuit1_set_reset with hand-computed z expectations.
module tb_circuit1_set_reset;

  logic clk;
  logic cd;
  logic sd;
  logic x1;
  logic x2;
  logic x3;
  logic z;

  int total;
  int bad;

  circuit1_set_reset dut (
    .clk (clk),
    .cd  (cd),
    .sd  (sd),
    .x1  (x1),
    .x2  (x2),
    .x3  (x3),
    .z   (z)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: z=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic setx(input logic [2:0] v);
    {x1, x2, x3} = v;
  endtask

  // One full clock: rising edge, then back low; caller samples while clk is low.
  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic step(input string tag, input logic [2:0] v, input logic exp);
    setx(v);
    #1;
    tick();
    chk(tag, z, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    cd    = 1'b0;
    sd    = 1'b1;
    setx(3'b110);
    #2;
    chk("reset_z", z, 1'b0);

    // clock edges held off by clear
    step("clr_hold0", 3'b110, 1'b0);
    step("clr_hold1", 3'b110, 1'b0);
    step("clr_hold2", 3'b110, 1'b0);
    cd = 1'b1;
    #2;
    chk("clr_release", z, 1'b0);

    // basic detect and drop
    step("seq_110", 3'b110, 1'b0);
    step("seq_111", 3'b111, 1'b0);
    step("seq_101", 3'b101, 1'b1);
    step("seq_000", 3'b000, 1'b0);

    // overlap: 110 from DETECT restarts the sequence
    step("ov_110", 3'b110, 1'b0);
    step("ov_111", 3'b111, 1'b0);
    step("ov_101", 3'b101, 1'b1);
    step("ov_re110", 3'b110, 1'b0);
    step("ov_re111", 3'b111, 1'b0);
    step("ov_re101", 3'b101, 1'b1);
    step("ov_end", 3'b000, 1'b0);

    // async set without clock, edges ignored while set held
    sd = 1'b0;
    #2;
    chk("set_async", z, 1'b1);
    step("set_hold", 3'b000, 1'b1);
    sd = 1'b1;
    #2;
    chk("set_release", z, 1'b1);
    step("set_exit", 3'b000, 1'b0);

    // clear beats set; releasing clear alone exposes set
    cd = 1'b0;
    sd = 1'b0;
    #2;
    chk("both_low", z, 1'b0);
    cd = 1'b1;
    #2;
    chk("clr_rel_set_held", z, 1'b1);
    sd = 1'b1;
    #2;
    chk("both_released", z, 1'b1);
    step("both_exit", 3'b000, 1'b0);

    // 110,111,110,111,101: GOT111 -> GOT110 restart path
    step("rs_110a", 3'b110, 1'b0);
    step("rs_111a", 3'b111, 1'b0);
    step("rs_110b", 3'b110, 1'b0);
    step("rs_111b", 3'b111, 1'b0);
    step("rs_101", 3'b101, 1'b1);
    step("rs_end", 3'b000, 1'b0);

    // 110,111,000,101: broken sequence
    step("br_110", 3'b110, 1'b0);
    step("br_111", 3'b111, 1'b0);
    step("br_000", 3'b000, 1'b0);
    step("br_101", 3'b101, 1'b0);

    // 101 alone from IDLE and 111 from GOT110 followed by 111 again
    step("id_101", 3'b101, 1'b0);
    step("rp_110", 3'b110, 1'b0);
    step("rp_111", 3'b111, 1'b0);
    step("rp_111b", 3'b111, 1'b0);
    step("rp_101", 3'b101, 1'b0);

    // clear pulse mid-cycle in GOT111 loses progress
    step("mc_110", 3'b110, 1'b0);
    step("mc_111", 3'b111, 1'b0);
    setx(3'b101);
    cd = 1'b0;
    #5;
    chk("mc_pulse", z, 1'b0);
    cd = 1'b1;
    #1;
    tick();
    chk("mc_101", z, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
